// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the CPU-to-system-bus memory bridge.
package mem_bridge_pkg;

    // Kind of memory access the execute stage hands to the bridge.
    typedef enum logic [2:0] {
        READ_LINE,
        READ,
        WRITE_B,
        WRITE_H,
        WRITE_W,
        WRITE_D
    } memory_access_t;

    // Bridge sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        ACK
    } state_t;

    // Words per cache line, i.e. the number of beats in a line fill.
    localparam int LINE_WORDS = 4;

    // Byte-enable pattern for an access before lane steering; reads use every lane.
    function automatic logic [7:0] size_mask(input memory_access_t access);
        case (access)
            WRITE_B: return 8'h01;
            WRITE_H: return 8'h03;
            WRITE_W: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // True for a multi-beat cache line fill.
    function automatic logic is_line(input memory_access_t access);
        return access == READ_LINE;
    endfunction

    // True for any store width.
    function automatic logic is_write(input memory_access_t access);
        case (access)
            WRITE_B, WRITE_H, WRITE_W, WRITE_D: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_bridge_lane.sv
// Byte-lane steering for single-beat stores: byte enables and shifted write data.
module mem_bridge_lane #(
    parameter int XLEN = 64
) (
    input  mem_bridge_pkg::memory_access_t access,
    input  logic [2:0]                     offset,
    input  logic [XLEN-1:0]                data,
    output logic [7:0]                     be,
    output logic [XLEN-1:0]                wdata
);
    import mem_bridge_pkg::*;

    // Stores shift mask and data up to the addressed byte; bytes pushed past the top are lost.
    always_comb begin
        be    = 8'hFF;
        wdata = '0;
        if (is_write(access)) begin
            be    = size_mask(access) << offset;
            wdata = data << {offset, 3'b000};
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// Turns CPU memory requests into one or LINE_WORDS request/acknowledge bus beats.
module mem_bridge #(
    parameter int XLEN       = 64,
    parameter int PLEN       = 34,
    parameter int LINE_WORDS = mem_bridge_pkg::LINE_WORDS
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            mem_cycle,
    input  logic [PLEN-1:0]                 mem_paddr,
    input  mem_bridge_pkg::memory_access_t  mem_access,
    input  logic [XLEN-1:0]                 mem_data_out,
    output logic [LINE_WORDS-1:0][XLEN-1:0] mem_data_in,
    output logic                            mem_ack,
    output logic                            bus_req,
    output logic                            bus_we,
    output logic [PLEN-4:0]                 bus_addr,
    output logic [7:0]                      bus_be,
    output logic [XLEN-1:0]                 bus_wdata,
    input  logic [XLEN-1:0]                 bus_rdata,
    input  logic                            bus_ack
);
    import mem_bridge_pkg::*;

    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
    localparam logic [PLEN-4:0] LINE_OFFSET = (PLEN-3)'(LINE_WORDS - 1);

    state_t         state;
    state_t         next_state;
    memory_access_t req_access;
    logic [CW-1:0]  cnt;
    logic           guard;
    logic           start;
    logic           beat_done;
    logic           more_beats;
    logic [7:0]     lane_be;
    logic [XLEN-1:0] lane_wdata;

    mem_bridge_lane #(
        .XLEN(XLEN)
    ) u_lane (
        .access(mem_access),
        .offset(mem_paddr[2:0]),
        .data  (mem_data_out),
        .be    (lane_be),
        .wdata (lane_wdata)
    );

    // The guard bit blocks the IDLE cycle right after ACK, so a request the CPU still holds is not reissued.
    assign start      = (state == IDLE) && mem_cycle && !guard;
    assign beat_done  = (state == BEAT) && bus_ack;
    assign more_beats = is_line(req_access) && (cnt != LAST_BEAT);
    assign bus_req    = (state == BEAT);
    assign mem_ack    = (state == ACK);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one beat per ack, line fills stay in BEAT until the last word.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = BEAT;
            BEAT: if (bus_ack && !more_beats) next_state = ACK;
            ACK:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latching, beat counting, address stepping and read-word assembly.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_access  <= READ_LINE;
            cnt         <= '0;
            guard       <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            mem_data_in <= '0;
        end else begin
            guard <= (state == ACK);
            if (start) begin
                req_access <= mem_access;
                cnt        <= '0;
                bus_we     <= is_write(mem_access);
                bus_be     <= lane_be;
                bus_wdata  <= lane_wdata;
                if (is_line(mem_access)) begin
                    bus_addr <= mem_paddr[PLEN-1:3] & ~LINE_OFFSET;
                end else begin
                    bus_addr <= mem_paddr[PLEN-1:3];
                end
            end
            if (beat_done) begin
                if (!is_write(req_access)) begin
                    mem_data_in[cnt] <= bus_rdata;
                end
                if (more_beats) begin
                    cnt      <= cnt + 1'b1;
                    bus_addr <= bus_addr + 1'b1;
                end
            end
            if (state == ACK) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the CPU memory interface. Consumes mem_cycle, mem_paddr, mem_access and mem_data_out; produces mem_data_in[3:0] and mem_ack.
- Converts each CPU request into one or four single-word beats on a simple request/acknowledge system bus.
- Cache line fills (32 B, 4 words) are assembled into mem_data_in before one mem_ack pulse.
- Single reads and writes use one beat, with byte-lane steering and byte enables.

Parameters:
- XLEN, 64: data word width; one bus beat carries one word.
- PLEN, 34: physical address width.
- LINE_WORDS, 4: words per cache line; the fill length.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_cycle  in  1  CPU request valid; held stable with mem_paddr, mem_access and mem_data_out until mem_ack.
- mem_paddr  in  PLEN  CPU physical byte address.
- mem_access  in  execute::memory_access_t  kind: READ_LINE, READ, WRITE_B, WRITE_H, WRITE_W, WRITE_D.
- mem_data_out  in  XLEN  write data, right-aligned.
- mem_data_in  out  4xXLEN  registered read data; word k is line word k.
- mem_ack  out  1  one-cycle completion pulse.
- bus_req  out  1  beat request; held until bus_ack.
- bus_we  out  1  write beat.
- bus_addr  out  PLEN-3  word address, byte address [PLEN-1:3].
- bus_be  out  8  byte enables; all ones for reads.
- bus_wdata  out  XLEN  lane-steered write data.
- bus_rdata  in  XLEN  read data, valid with bus_ack.
- bus_ack  in  1  beat done; may assert in the same cycle bus_req first rises.

Behaviour:
- Reset values: state IDLE; mem_ack=0; bus_req=0; bus_we=0; bus_addr=0; bus_be=0; bus_wdata=0; mem_data_in all words 0; beat counter 0.
- FSM has three states: IDLE, BEAT, ACK.
- IDLE, mem_cycle=1 at edge N:
  - Latch the request.
  - Enter BEAT; bus_req=1 from cycle N+1.
  - Set bus_addr:
    - READ_LINE: {paddr[PLEN-1:5], 2'b00}.
    - Otherwise: paddr[PLEN-1:3].
- BEAT, bus_ack=1:
  - Reads: capture bus_rdata into mem_data_in[cnt]. Single READ always writes word 0; words 1-3 keep their old values.
  - READ_LINE with cnt<3: cnt++, bus_addr++, bus_req stays 1 with no gap cycle.
  - Otherwise: bus_req=0 at that edge; enter ACK.
  - bus_ack while bus_req=0 (IDLE or ACK) is ignored.
- ACK:
  - mem_ack=1 for exactly one cycle; then IDLE, cnt=0.
  - mem_cycle is not sampled in ACK or in the IDLE cycle immediately after ACK. This guard cycle prevents re-issuing a request the CPU has not yet dropped.
  - Minimum request-to-request spacing: 4 cycles with a zero-wait slave.
- Latency, zero-wait slave (mem_cycle sampled at edge N):
  - READ/WRITE: mem_ack in cycle N+2.
  - READ_LINE: mem_ack in cycle N+5.
- Writes:
  - bus_we=1.
  - bus_be = size mask shifted left by paddr[2:0]. Size masks: B=0x01, H=0x03, W=0x0F, D=0xFF.
  - bus_wdata = mem_data_out << (8*paddr[2:0]).
  - Alignment is guaranteed by the execute stage. If an access is misaligned, the bytes shifted beyond bit 63 are dropped; no error is raised.
- Read data:
  - The returned word is raw and 8-byte aligned; extraction and sign extension belong to the execute stage.
  - mem_data_in changes only on beat acks.
- mem_cycle dropping mid-operation: the bridge still completes all beats and pulses mem_ack.
- Reset mid-operation: at that edge bus_req drops to 0 and the state returns to IDLE; the partial line is discarded and mem_data_in is cleared.
- Slave stall: bus_req, bus_addr, bus_we, bus_be and bus_wdata stay stable for unbounded wait states.
- The bridge never has more than one beat outstanding.

Decomposition:
- Package mem_bridge_pkg:
  - state_t enum {IDLE, BEAT, ACK}.
  - LINE_WORDS constant.
  - Function size_mask(memory_access_t) returning 8 bits.
  - Function is_line/is_write helpers.
- Sub-module mem_bridge_lane: combinational; generates bus_be and bus_wdata from access kind, paddr[2:0] and mem_data_out.
- The FSM, counter and read assembly stay in mem_bridge.

Test Plan:
- READ_LINE at paddr 0x0000_1048, zero-wait slave returning 0xA0..0xA3 -> bus_addr 0x208, 0x209, 0x20A, 0x20B on consecutive cycles; mem_data_in = {0xA3, 0xA2, 0xA1, 0xA0}; mem_ack in cycle N+5, exactly one cycle.
- WRITE_H at paddr 0x106, data 0xBEEF -> bus_be=0xC0, bus_wdata=0xBEEF_0000_0000_0000, bus_we=1; mem_ack follows the beat ack by one cycle.
- READ at paddr 0x40, slave with 3 wait states, rdata 0x1234 -> bus_req held 4 cycles with stable address 0x8; mem_data_in[0]=0x1234; words 1-3 unchanged from the prior fill.
- mem_cycle held high through mem_ack and the following cycle -> no second bus_req is issued until mem_cycle is resampled in the next IDLE cycle.
- Reset asserted during beat 2 of a line fill -> bus_req=0 and mem_ack=0 the cycle after; mem_data_in all zero; a stray bus_ack afterwards has no effect.
- Back-to-back WRITE_D then READ_LINE -> no beat overlap; both mem_ack pulses observed; spacing ≥4 cycles.
